// File: rtl/rob_pkg.sv
// rob_pkg: shared ROB sizing, packet layout and index types
package rob_pkg;
  localparam int N = 3;
  localparam int ROB_SZ = 32;
  localparam int IDX_BITS = $clog2(ROB_SZ);
  localparam int CNT_BITS = $clog2(ROB_SZ + 1);
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  typedef logic [IDX_BITS-1:0] ROB_IDX;
  typedef logic [CNT_BITS-1:0] rob_cnt_t;
  typedef logic [NUM_SCALAR_BITS-1:0] num_scalar_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest_reg;
    logic        halt;
  } ROB_PACKET;
  function automatic num_scalar_t min_n(input rob_cnt_t x);
    return (x < rob_cnt_t'(N)) ? num_scalar_t'(x) : num_scalar_t'(N);
  endfunction
endpackage

// File: rtl/rob_if.sv
// rob_if: dispatch/retire side of the reorder buffer; ROB_TAIL_RESTORE_EN adds tail restore signals
interface rob_if;
  import rob_pkg::*;
  ROB_PACKET [N-1:0] rob_inputs;
  num_scalar_t       num_dispatch;
  num_scalar_t       rob_spots;
  ROB_IDX            rob_tail_idx;
  ROB_PACKET [N-1:0] rob_outputs;
  num_scalar_t       rob_outputs_valid;
  num_scalar_t       num_retiring;
  logic              flush;
`ifdef ROB_TAIL_RESTORE_EN
  logic              tail_restore_valid;
  ROB_IDX            tail_restore_idx;
  modport master (output rob_inputs, num_dispatch, num_retiring, flush, tail_restore_valid, tail_restore_idx,
                  input rob_spots, rob_tail_idx, rob_outputs, rob_outputs_valid);
  modport slave (input rob_inputs, num_dispatch, num_retiring, flush, tail_restore_valid, tail_restore_idx,
                 output rob_spots, rob_tail_idx, rob_outputs, rob_outputs_valid);
`else
  modport master (output rob_inputs, num_dispatch, num_retiring, flush,
                  input rob_spots, rob_tail_idx, rob_outputs, rob_outputs_valid);
  modport slave (input rob_inputs, num_dispatch, num_retiring, flush,
                 output rob_spots, rob_tail_idx, rob_outputs, rob_outputs_valid);
`endif
endinterface

// File: rtl/rob.sv
// rob: circular reorder buffer, N-wide dispatch at tail, N-wide retire window at head; ROB_TAIL_RESTORE_EN adds tail restore
module rob
  import rob_pkg::*;
(
  input logic  clock,
  input logic  reset,
  rob_if.slave rif
);
  ROB_PACKET   mem_q [ROB_SZ];
  ROB_IDX      head_q, head_d, tail_q, tail_d;
  rob_cnt_t    count_q, count_d;
  num_scalar_t spots, valid, d, r;
  logic        we;
`ifdef ROB_TAIL_RESTORE_EN
  rob_cnt_t    keep;
  assign keep = rob_cnt_t'(rif.tail_restore_idx - head_q) + rob_cnt_t'(1);
`endif
  // limits come from registered count only, so retire cannot loop back into dispatch
  always_comb begin
    spots = min_n(rob_cnt_t'(ROB_SZ) - count_q);
    valid = min_n(count_q);
    d = (rif.num_dispatch > spots) ? spots : rif.num_dispatch;
    r = (rif.num_retiring > valid) ? valid : rif.num_retiring;
  end
  assign rif.rob_spots = spots;
  assign rif.rob_outputs_valid = valid;
  assign rif.rob_tail_idx = tail_q;
  // head window, zeroed beyond the valid count
  always_comb begin
    for (int i = 0; i < N; i++)
      rif.rob_outputs[i] = (num_scalar_t'(i) < valid) ? mem_q[head_q + ROB_IDX'(i)] : '0;
  end
  // next pointers: flush beats restore beats normal dispatch/retire
  always_comb begin
    head_d = head_q + ROB_IDX'(r);
    tail_d = tail_q + ROB_IDX'(d);
    count_d = count_q + rob_cnt_t'(d) - rob_cnt_t'(r);
    we = !rif.flush;
`ifdef ROB_TAIL_RESTORE_EN
    if (rif.tail_restore_valid) begin
      tail_d = rif.tail_restore_idx + ROB_IDX'(1);
      count_d = keep - rob_cnt_t'(r);
      we = 1'b0;
    end
`endif
    if (rif.flush) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
  end
  // pointer and occupancy registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage, written at the tail; contents need no reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++)
      if (we && num_scalar_t'(i) < d) mem_q[tail_q + ROB_IDX'(i)] <= rif.rob_inputs[i];
  end
`ifdef ROB_TAIL_RESTORE_EN
  // the restored branch itself must not be retiring in the same cycle
  assert property (@(posedge clock) disable iff (!reset)
    (rif.tail_restore_valid && !rif.flush) |-> (keep > rob_cnt_t'(r)));
`endif
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed checks of the reorder buffer; ROB_TAIL_RESTORE_EN enables the restore checks
module tb_rob;
  import rob_pkg::*;
  logic clock;
  logic reset;
  int n_chk = 0;
  int n_err = 0;
  rob_if rif ();
  rob u_rob (.clock(clock), .reset(reset), .rif(rif));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input int nd, input int nr, input int pc0);
    for (int i = 0; i < N; i++) begin
      rif.rob_inputs[i] = '0;
      rif.rob_inputs[i].pc = 32'(pc0 + i);
    end
    rif.num_dispatch = num_scalar_t'(nd);
    rif.num_retiring = num_scalar_t'(nr);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    drive(0, 0, 0);
    rif.flush = 1'b0;
`ifdef ROB_TAIL_RESTORE_EN
    rif.tail_restore_valid = 1'b0;
    rif.tail_restore_idx = '0;
`endif
  endtask
  initial begin
    reset = 1'b0;
    rif.flush = 1'b0;
`ifdef ROB_TAIL_RESTORE_EN
    rif.tail_restore_valid = 1'b0;
    rif.tail_restore_idx = '0;
`endif
    drive(0, 0, 0);
    #2;
    chk("rst_valid", rif.rob_outputs_valid, 0);
    chk("rst_spots", rif.rob_spots, 3);
    chk("rst_tail", rif.rob_tail_idx, 0);
    chk("rst_out0", rif.rob_outputs[0], 0);
    @(posedge clock);
    #1 reset = 1'b1;
    // fill to 30 entries, pc = dispatch order
    for (int c = 0; c < 10; c++) begin
      drive(3, 0, 3 * c);
      #1 chk("fill_spots", rif.rob_spots, 3);
      tick();
    end
    chk("c30_spots", rif.rob_spots, 2);
    chk("c30_valid", rif.rob_outputs_valid, 3);
    chk("c30_tail", rif.rob_tail_idx, 30);
    chk("c30_out0", rif.rob_outputs[0].pc, 0);
    chk("c30_out2", rif.rob_outputs[2].pc, 2);
    // over-dispatch clamps to the 2 free spots
    drive(3, 0, 30);
    tick();
    chk("full_spots", rif.rob_spots, 0);
    chk("full_tail", rif.rob_tail_idx, 0);
    // full: retire does not free spots in the same cycle
    drive(3, 3, 40);
    #1 chk("full_ret_spots", rif.rob_spots, 0);
    tick();
    chk("c29_spots", rif.rob_spots, 3);
    chk("c29_out0", rif.rob_outputs[0].pc, 3);
    chk("c29_out2", rif.rob_outputs[2].pc, 5);
    chk("c29_tail", rif.rob_tail_idx, 0);
    // drain to head=30, count=2
    for (int c = 0; c < 9; c++) begin
      drive(0, 3, 0);
      tick();
    end
    chk("h30_valid", rif.rob_outputs_valid, 2);
    chk("h30_out0", rif.rob_outputs[0].pc, 30);
    chk("h30_out1", rif.rob_outputs[1].pc, 31);
    chk("h30_out2_zero", rif.rob_outputs[2], 0);
    drive(3, 0, 100);
    tick();
    chk("wrap_valid", rif.rob_outputs_valid, 3);
    chk("wrap_out0", rif.rob_outputs[0].pc, 30);
    chk("wrap_out1", rif.rob_outputs[1].pc, 31);
    chk("wrap_out2", rif.rob_outputs[2].pc, 100);
    chk("wrap_tail", rif.rob_tail_idx, 3);
    drive(3, 3, 200);
    tick();
    chk("h1_out0", rif.rob_outputs[0].pc, 101);
    chk("h1_out1", rif.rob_outputs[1].pc, 102);
    chk("h1_out2", rif.rob_outputs[2].pc, 200);
    chk("h1_tail", rif.rob_tail_idx, 6);
    drive(0, 1, 0);
    tick();
    chk("c4_out0", rif.rob_outputs[0].pc, 102);
    // count=4, dispatch 2 and retire 3 together
    drive(2, 3, 300);
    tick();
    chk("mix_valid", rif.rob_outputs_valid, 3);
    chk("mix_out0", rif.rob_outputs[0].pc, 202);
    chk("mix_out1", rif.rob_outputs[1].pc, 300);
    chk("mix_out2", rif.rob_outputs[2].pc, 301);
    chk("mix_tail", rif.rob_tail_idx, 8);
    // flush drops everything
    drive(3, 2, 400);
    rif.flush = 1'b1;
    tick();
    chk("fl_valid", rif.rob_outputs_valid, 0);
    chk("fl_spots", rif.rob_spots, 3);
    chk("fl_tail", rif.rob_tail_idx, 0);
    chk("fl_out0", rif.rob_outputs[0], 0);
    // empty: no bypass of same-cycle dispatch
    drive(1, 0, 500);
    #1 chk("nobyp_valid", rif.rob_outputs_valid, 0);
    tick();
    chk("post_valid", rif.rob_outputs_valid, 1);
    chk("post_out0", rif.rob_outputs[0].pc, 500);
    chk("post_tail", rif.rob_tail_idx, 1);
`ifdef ROB_TAIL_RESTORE_EN
    reset = 1'b0;
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(3, 0, 600 + 3 * c);
      tick();
    end
    drive(0, 3, 0);
    tick();
    drive(0, 2, 0);
    tick();
    chk("pre_rs_out0", rif.rob_outputs[0].pc, 605);
    chk("pre_rs_tail", rif.rob_tail_idx, 15);
    drive(3, 2, 700);
    rif.tail_restore_valid = 1'b1;
    rif.tail_restore_idx = ROB_IDX'(8);
    tick();
    chk("rs_tail", rif.rob_tail_idx, 9);
    chk("rs_valid", rif.rob_outputs_valid, 2);
    chk("rs_out0", rif.rob_outputs[0].pc, 607);
    chk("rs_out1", rif.rob_outputs[1].pc, 608);
    chk("rs_spots", rif.rob_spots, 3);
`endif
    // asynchronous reset mid-burst
    drive(3, 0, 800);
    tick();
    chk("pre_ar_valid", rif.rob_outputs_valid, 3);
    drive(3, 0, 900);
    #3 reset = 1'b0;
    #1;
    chk("ar_valid", rif.rob_outputs_valid, 0);
    chk("ar_spots", rif.rob_spots, 3);
    chk("ar_tail", rif.rob_tail_idx, 0);
    chk("ar_out0", rif.rob_outputs[0], 0);
    drive(0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    #1 chk("ar_lost", rif.rob_outputs_valid, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer. Circular in-order buffer of ROB_PACKET entries.
- Sits between dispatch (upstream, writes up to N entries per cycle at the tail) and the retire stage (downstream).
- Every cycle, presents the oldest up to N entries at the head to retire. Frees however many entries retire reports back.
- Supports a full pipeline flush on a retiring mispredict.

Parameters:
- N, 3, superscalar width (matches `N).
- ROB_SZ, 32, number of entries; power of two, at least 2*N.
- IDX_BITS, $clog2(ROB_SZ), entry index width.
- CNT_BITS, $clog2(ROB_SZ+1), occupancy counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rob_inputs  in  N x ROB_PACKET  dispatched entries, oldest at index 0.
- num_dispatch  in  NUM_SCALAR_BITS  count of valid rob_inputs (0..N).
- rob_spots  out  NUM_SCALAR_BITS  entries dispatch may write this cycle.
- rob_tail_idx  out  IDX_BITS  index the rob_inputs[0] entry will occupy.
- rob_outputs  out  N x ROB_PACKET  head entries, oldest at index 0.
- rob_outputs_valid  out  NUM_SCALAR_BITS  count of valid rob_outputs.
- num_retiring  in  NUM_SCALAR_BITS  entries retired this cycle (from retire).
- flush  in  1  squash all entries (mispredict at retire).

Behaviour:
- State: entry array[ROB_SZ], head, tail (IDX_BITS), count (CNT_BITS). Array contents are not reset.
- Reset (reset==0, asynchronous): head=0, tail=0, count=0. Consequently rob_outputs_valid=0, rob_spots=min(N,ROB_SZ)=N, rob_tail_idx=0, rob_outputs=all zero.
- rob_spots = min(N, ROB_SZ-count).
  - Combinational from registered count only; does not credit same-cycle num_retiring. This avoids a comb loop through retire.
- rob_outputs_valid = min(N, count).
- rob_outputs[i] = array[(head+i) mod ROB_SZ] when i < rob_outputs_valid, else all zero.
- Output latency:
  - An entry dispatched in cycle t is visible on rob_outputs in cycle t+1 at the earliest, when it sits within the first N entries from head.
  - Retire sees it combinationally and may retire it in t+1.
- Dispatch write at the clock edge: array[(tail+i) mod ROB_SZ] <= rob_inputs[i] for i < d.
  - d = min(num_dispatch, rob_spots).
  - num_dispatch > rob_spots is a protocol violation; the RTL clamps to rob_spots.
- Retire: head <= (head + r) mod ROB_SZ.
  - r = min(num_retiring, rob_outputs_valid); clamped the same way.
- Pointer and counter update:
  - tail <= (tail + d) mod ROB_SZ.
  - count <= count + d - r.
  - Simultaneous dispatch and retire are both applied in the same edge.
- Wrap-around: all index arithmetic is modulo ROB_SZ via IDX_BITS truncation. N-wide reads and writes straddling index ROB_SZ-1 → 0 must be correct.
- Full: count==ROB_SZ gives rob_spots=0. Retiring r in that cycle does not raise rob_spots until the next cycle.
- Empty: count==0 gives rob_outputs_valid=0. Entries dispatched that cycle are not bypassed to rob_outputs.
- Flush: highest priority. Next edge: head=0, tail=0, count=0, regardless of num_dispatch or num_retiring.
  - Retire still commits its own entries that cycle; the ROB just drops everything.
- Reset mid-operation: immediate return to the reset state; any in-flight dispatch is lost.

Optional Feature:
- Macro: ROB_TAIL_RESTORE_EN.
- Defined:
  - Adds input tail_restore_valid (1) and input tail_restore_idx (IDX_BITS), the ROB index of a mispredicted branch resolved in execute.
  - When tail_restore_valid=1 and flush=0:
    - tail <= tail_restore_idx+1.
    - keep = ((tail_restore_idx - head) mod ROB_SZ) + 1.
    - count <= keep - r.
    - Dispatch that cycle is ignored.
  - flush overrides restore.
  - The branch entry must not be retiring the same cycle (keep > r); this is asserted.
- Undefined: ports absent; only full flush recovery.

Decomposition:
- Shared package (sys_defs.svh): ROB_PACKET, `N, `ROB_SZ, NUM_SCALAR_BITS, ROB index typedef ROB_IDX.
- No sub-module needed. Dispatch-write and head-read index generation are plain for-loops in always_comb/always_ff.

Test Plan:
- Reset, then dispatch 3 per cycle for 10 cycles with retire 0 → count reaches 30, rob_spots=2 in cycle 11, then 0 after dispatching 2 more (full).
- Full ROB, num_retiring=3 with num_dispatch=3 → rob_spots=0 that cycle; next cycle count=29, rob_spots=3, head advanced by 3.
- head=30, count=5 → rob_outputs[0..2] = array[30], array[31], array[0]; after num_retiring=3, head=1. Dispatch at tail=3 wraps correctly.
- count=4, num_dispatch=2, num_retiring=3 simultaneously → count=3, rob_outputs_valid=3 next cycle, ordering preserved.
- flush with num_dispatch=3 and num_retiring=2 → next cycle head=tail=count=0, rob_outputs_valid=0, rob_spots=3.
- ROB_TAIL_RESTORE_EN: head=5, count=10, restore idx=8, r=2 → tail=9, count=2, dispatch that cycle dropped. Async reset asserted mid-burst → outputs zeroed immediately without a clock edge.
